tcp_tx_ctrl: RTL

- Transmit-side executor for TCP control commands issued by the connection state machine.
- Accepts one tx_ctrl_t command per valid/ack handshake and tracks the send sequence number (SND.NXT).
- Emits the corresponding 20-byte TCP header, without options, as five 32-bit words on a stream interface into the IPv4 encapsulation path.
- The checksum field is sent as zero; the downstream IP/checksum stage fills it.

---
 rtl/tcp_pkg.sv | 40 ++++
 rtl/tcp_tx_ctrl.sv | 138 +++++++++++++
 2 files changed

// File: rtl/tcp_pkg.sv
// Shared types and constants for the TCP transmit-control path.
// Command encoding, header flag values and fixed header geometry.
package tcp_pkg;

  typedef enum logic [2:0] {
    TX_CTRL_NOP      = 3'd0,
    TX_CTRL_SEND_SYN = 3'd1,
    TX_CTRL_SEND_ACK = 3'd2,
    TX_CTRL_SEND_FIN = 3'd3,
    TX_CTRL_SEND_RST = 3'd4
  } tx_ctrl_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } tx_state_t;

  localparam logic [7:0] TCP_FLAG_FIN = 8'h01;
  localparam logic [7:0] TCP_FLAG_SYN = 8'h02;
  localparam logic [7:0] TCP_FLAG_RST = 8'h04;
  localparam logic [7:0] TCP_FLAG_ACK = 8'h10;

  localparam int TCP_HDR_WORDS = 5;
  localparam logic [3:0] TCP_DATA_OFFSET = 4'd5;

  // Flag byte carried in the header for each command; FIN also acknowledges.
  function automatic logic [7:0] tcp_flags_for(input tx_ctrl_t cmd);
    logic [7:0] f;
    f = 8'h00;
    case (cmd)
      TX_CTRL_SEND_SYN: f = TCP_FLAG_SYN;
      TX_CTRL_SEND_ACK: f = TCP_FLAG_ACK;
      TX_CTRL_SEND_FIN: f = TCP_FLAG_FIN | TCP_FLAG_ACK;
      TX_CTRL_SEND_RST: f = TCP_FLAG_RST;
      default:          f = 8'h00;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/tcp_tx_ctrl.sv
// Executes TCP control commands: tracks SND.NXT and streams a 20-byte header.
// Handshake: a command is taken when o_tx_ctrl_ack=1 (same cycle as valid); a stream word moves when o_tvalid & i_tready.
module tcp_tx_ctrl
  import tcp_pkg::*;
#(
  parameter logic [15:0] WINDOW        = 16'h0400,
  parameter int          NUM_HDR_WORDS = TCP_HDR_WORDS
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_enable,
  input  logic [15:0] i_src_port,
  input  logic [15:0] i_dst_port,
  input  logic [31:0] i_isn,
  input  logic [31:0] i_rcv_nxt,
  input  tx_ctrl_t    i_tx_ctrl,
  input  logic        i_tx_ctrl_valid,
  output logic        o_tx_ctrl_ack,
  output logic [31:0] o_snd_nxt,
  output logic [31:0] o_tdata,
  output logic        o_tvalid,
  input  logic        i_tready,
  output logic        o_tlast,
  output logic        o_busy
);

  localparam logic [2:0] LAST_K = 3'(NUM_HDR_WORDS - 1);

  tx_state_t   state_q, state_d;
  logic [2:0]  k_q;
  logic [31:0] ports_q;
  logic [31:0] seq_q;
  logic [31:0] ack_num_q;
  logic [7:0]  flags_q;
  logic [31:0] snd_nxt_q;
  logic        accept;
  logic        xfer;

  function automatic logic [31:0] hdr_word(
    input logic [2:0]  k,
    input logic [31:0] ports,
    input logic [31:0] seq,
    input logic [31:0] ack_num,
    input logic [7:0]  flags
  );
    logic [31:0] w;
    w = 32'h0;
    case (k)
      3'd0:    w = ports;
      3'd1:    w = seq;
      3'd2:    w = ack_num;
      3'd3:    w = {TCP_DATA_OFFSET, 4'd0, flags, WINDOW};
      default: w = 32'h0;
    endcase
    return w;
  endfunction

  assign xfer = (state_q == ST_SEND) && i_tready;

  // Ack is combinational so the requester can advance in the accept cycle.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_enable && i_tx_ctrl_valid && (i_tx_ctrl != TX_CTRL_NOP)) begin
          accept  = 1'b1;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (i_tready && (k_q == LAST_K)) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      k_q <= 3'd0;
    end else if (xfer) begin
      k_q <= (k_q == LAST_K) ? 3'd0 : k_q + 3'd1;
    end
  end

  // Header fields are frozen at accept so the words stay stable under backpressure.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ports_q   <= 32'h0;
      seq_q     <= 32'h0;
      ack_num_q <= 32'h0;
      flags_q   <= 8'h0;
      snd_nxt_q <= 32'h0;
    end else if (accept) begin
      ports_q <= {i_src_port, i_dst_port};
      flags_q <= tcp_flags_for(i_tx_ctrl);
      case (i_tx_ctrl)
        TX_CTRL_SEND_SYN: begin
          seq_q     <= i_isn;
          ack_num_q <= 32'h0;
          snd_nxt_q <= i_isn + 32'd1;
        end
        TX_CTRL_SEND_FIN: begin
          seq_q     <= snd_nxt_q;
          ack_num_q <= i_rcv_nxt;
          snd_nxt_q <= snd_nxt_q + 32'd1;
        end
        TX_CTRL_SEND_ACK: begin
          seq_q     <= snd_nxt_q;
          ack_num_q <= i_rcv_nxt;
        end
        default: begin
          seq_q     <= snd_nxt_q;
          ack_num_q <= 32'h0;
        end
      endcase
    end
  end

  assign o_tx_ctrl_ack = accept;
  assign o_snd_nxt     = snd_nxt_q;
  assign o_tvalid      = (state_q == ST_SEND);
  assign o_busy        = (state_q == ST_SEND);
  assign o_tlast       = (state_q == ST_SEND) && (k_q == LAST_K);
  assign o_tdata       = (state_q == ST_SEND) ?
                         hdr_word(k_q, ports_q, seq_q, ack_num_q, flags_q) : 32'h0;

endmodule
